// File: rtl/sh_hf_pkg.sv
// -----------------------------------------------------------------------------
// sh_hf_pkg : shared types and constants for the Steelhorse receive buffer
// Revision  : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package sh_hf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    NOTIFY = 2'd2
  } drain_state_e;

  localparam logic [1:0] TURN_SLOT_DEFAULT = 2'b01;
  localparam int         DROP_CNT_W        = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sh_hf_eopq.sv
// -----------------------------------------------------------------------------
// sh_hf_eopq : small synchronous FIFO holding end-of-packet word addresses
// Revision   : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sh_hf_eopq #(
  parameter int AW    = 5,
  parameter int QLOG2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] din,
  input  logic          pop,
  output logic [AW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int            CW     = QLOG2 + 1;
  localparam logic [CW-1:0] QDEPTH = CW'(1 << QLOG2);

  logic [AW-1:0] slots [1 << QLOG2];
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = ((wptr - rptr) == QDEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rptr[QLOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + CW'(1);
      if (do_pop)  rptr <= rptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wptr[QLOG2-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/sh_hf_recv_buffer.sv
// -----------------------------------------------------------------------------
// sh_hf_recv_buffer : packet-aware receive buffer, Steelhorse RX -> LSAB write
// Revision          : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sh_hf_recv_buffer
  import sh_hf_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 4,
  parameter int         EOPQ_LOG2  = 2,
  parameter logic [1:0] TURN_SLOT  = TURN_SLOT_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           DATA_IN,
  input  logic                  WRITE_IN,
  input  logic                  NEW_PCKT,
  input  logic                  NEW_PCKT_VALID,
  input  logic [1:0]            LSAB_TURN,
  output logic [31:0]           DATA_OUT,
  output logic                  WRITE,
  output logic                  IRQ,
  output logic                  IRQ_VLD,
  output logic [DROP_CNT_W-1:0] DROP_CNT,
  output logic                  OVERFLOW
);

  localparam int            PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << DEPTH_LOG2);

  logic [31:0]   mem [1 << DEPTH_LOG2];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic          dropping;

  logic          buf_full;
  logic          accept;
  logic          word_overflow;
  logic          drop_now;
  logic          has_words;
  logic [PW-1:0] wr_next;
  logic          close_good;
  logic          close_drop;
  logic          close_ovf;

  logic          eop_full;
  logic          eop_empty;
  logic          eop_pop;
  logic [PW-1:0] eop_head;

  drain_state_e  state;
  drain_state_e  state_nx;
  logic          do_write;
  logic          has_committed;
  logic          turn_hit;
  logic [PW-1:0] rd_next;

  // ---------------------------------------------------------------------------
  // Ingress
  // ---------------------------------------------------------------------------
  assign buf_full      = ((wr_ptr - rd_ptr) == DEPTH);
  assign accept        = WRITE_IN && !buf_full && !dropping;
  assign word_overflow = WRITE_IN && buf_full && !dropping;
  assign drop_now      = dropping || word_overflow;
  assign wr_next       = wr_ptr + PW'(accept);
  assign has_words     = (wr_next != commit_ptr);

  // A word arriving with the strobe is already folded into wr_next.
  always_comb begin
    close_good = 1'b0;
    close_drop = 1'b0;
    close_ovf  = 1'b0;
    if (NEW_PCKT) begin
      if (drop_now) begin
        close_drop = 1'b1;
        close_ovf  = 1'b1;
      end else if (!NEW_PCKT_VALID) begin
        close_drop = 1'b1;
      end else if (has_words) begin
        if (eop_full) begin
          close_drop = 1'b1;
          close_ovf  = 1'b1;
        end else begin
          close_good = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      dropping   <= 1'b0;
      DROP_CNT   <= '0;
      OVERFLOW   <= 1'b0;
    end else if (close_drop) begin
      wr_ptr   <= commit_ptr;
      dropping <= 1'b0;
      DROP_CNT <= sat_inc(DROP_CNT);
      if (close_ovf) OVERFLOW <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      if (close_good)    commit_ptr <= wr_next;
      if (word_overflow) dropping   <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr[DEPTH_LOG2-1:0]] <= DATA_IN;
  end

  sh_hf_eopq #(
    .AW    (PW),
    .QLOG2 (EOPQ_LOG2)
  ) u_eopq (
    .clk   (CLK),
    .rst_n (RST),
    .push  (close_good),
    .din   (wr_next - PW'(1)),
    .pop   (eop_pop),
    .head  (eop_head),
    .full  (eop_full),
    .empty (eop_empty)
  );

  assign IRQ_VLD = !eop_empty;

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  assign has_committed = (rd_ptr != commit_ptr);
  assign turn_hit      = (LSAB_TURN == TURN_SLOT);
  assign rd_next       = rd_ptr + PW'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_write = 1'b0;
    eop_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (has_committed) state_nx = DRAIN;
      end
      DRAIN: begin
        if (turn_hit && has_committed) begin
          do_write = 1'b1;
          if (!eop_empty && (rd_ptr == eop_head)) begin
            eop_pop  = 1'b1;
            state_nx = NOTIFY;
          end else if (rd_next == commit_ptr) begin
            state_nx = IDLE;
          end
        end else if (!has_committed) begin
          state_nx = IDLE;
        end
      end
      NOTIFY: begin
        state_nx = has_committed ? DRAIN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // IRQ is registered off NOTIFY so it lands the cycle after the last WRITE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr   <= '0;
      DATA_OUT <= '0;
      WRITE    <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      WRITE <= do_write;
      IRQ   <= (state == NOTIFY);
      if (do_write) begin
        DATA_OUT <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr   <= rd_next;
      end
    end
  end

endmodule

`default_nettype wire
